// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the host command/response handshake and the two-slave APB bus used
// by apb_master_bridge.
//   Host side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_strb in,
//               rsp_valid/rsp_rdata/rsp_err/rsp_timeout/busy out of the bridge
//   APB side  : psel[1:0]/penable/pwrite/padd/pwdata/pstrb out of the bridge,
//               prdataN/preadyN/pslevrrN from slave 0 (UART) and slave 1 (GPIO)
// Modports:
//   master - the bridge's view (drives responses and the APB request signals)
//   slave  - the surrounding host/peripheral view (the mirror image)
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Host command / response
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    // APB request
    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] padd;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;

    // APB completions from the two slaves
    logic [DATA_W-1:0] prdata0;
    logic [DATA_W-1:0] prdata1;
    logic              pready0;
    logic              pready1;
    logic              pslevrr0;
    logic              pslevrr1;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output psel, penable, pwrite, padd, pwdata, pstrb,
        input  prdata0, prdata1, pready0, pready1, pslevrr0, pslevrr1
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  psel, penable, pwrite, padd, pwdata, pstrb,
        output prdata0, prdata1, pready0, pready1, pslevrr0, pslevrr1
    );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Turns single host commands into APB transfers to one of two slaves:
//   slave 0 (UART, 0x70-0x7F) and slave 1 (GPIO, 0x80-0x8F).
// Any other address completes immediately with an error and no bus activity.
// A pready timeout keeps a hung slave from stalling the host.
// Ports:
//   pclk - clock, all logic on the rising edge
//   rst  - asynchronous active-high reset; aborts any transfer silently
//   bus  - apb_master_bridge_if.master: host cmd/rsp handshake and APB bus
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles without pready before abort (0 = never)
//   ADDR_W, DATA_W - APB address / data widths (ADDR_W must be at least 9)
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                  pclk,
    input  logic                  rst,
    apb_master_bridge_if.master   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen on the last permitted waiting ACCESS cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_strb;
    logic [1:0]        r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_timeout;

    logic              w_accept;
    logic              w_dec_s0;
    logic              w_dec_s1;
    logic              w_pready;
    logic              w_pslverr;
    logic [DATA_W-1:0] w_prdata;
    logic              w_to_hit;

    assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
    assign w_dec_s0 = (bus.cmd_addr[ADDR_W-1:8] == '0) && (bus.cmd_addr[7:4] == 4'h7);
    assign w_dec_s1 = (bus.cmd_addr[ADDR_W-1:8] == '0) && (bus.cmd_addr[7:4] == 4'h8);

    // Only the selected slave's completion signals are looked at.
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        if (r_sel[0]) begin
            w_pready  = bus.pready0;
            w_pslverr = bus.pslevrr0;
            w_prdata  = bus.prdata0;
        end else if (r_sel[1]) begin
            w_pready  = bus.pready1;
            w_pslverr = bus.pslevrr1;
            w_prdata  = bus.prdata1;
        end
    end

    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Undecoded addresses skip the bus and report an error.
                    w_next = (w_dec_s0 || w_dec_s1) ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_pready || w_to_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command capture, wait counter and response capture
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.cmd_write;
                        r_addr  <= bus.cmd_addr;
                        r_wdata <= bus.cmd_wdata;
                        r_strb  <= bus.cmd_write ? bus.cmd_strb : 4'b0000;
                        r_sel   <= {w_dec_s1, w_dec_s0};
                        r_cnt   <= '0;
                        if (!(w_dec_s0 || w_dec_s1)) begin
                            r_rdata   <= '0;
                            r_err     <= 1'b1;
                            r_timeout <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        // Read data is returned even alongside a slave error.
                        r_rdata   <= r_write ? '0 : w_prdata;
                        r_err     <= w_pslverr;
                        r_timeout <= 1'b0;
                        r_cnt     <= '0;
                    end else if (w_to_hit) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.busy        = 1'b0;
        bus.psel        = 2'b00;
        bus.penable     = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.pwrite      = r_write;
        bus.padd        = r_addr;
        bus.pwdata      = r_wdata;
        bus.pstrb       = r_strb;
        bus.rsp_rdata   = r_rdata;
        bus.rsp_err     = r_err;
        bus.rsp_timeout = r_timeout;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
            end
            S_SETUP: begin
                bus.busy = 1'b1;
                bus.psel = r_sel;
            end
            S_ACCESS: begin
                bus.busy    = 1'b1;
                bus.psel    = r_sel;
                bus.penable = 1'b1;
            end
            S_RESP: begin
                bus.busy      = 1'b1;
                bus.rsp_valid = 1'b1;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed bench for apb_master_bridge built with TIMEOUT_CYCLES = 8.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    logic pclk;
    logic rst;
    int   checks;
    int   errors;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .TIMEOUT_CYCLES(8),
        .ADDR_W        (32),
        .DATA_W        (32)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Presents a command and returns 1 ns after the accept edge.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_wait: cmd_ready=%b required 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err,
             bus.rsp_timeout, bus.pwrite, bus.pstrb} !== 13'b1_0_00_0_0_0_0_0_0000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy=%b busy=%b psel=%b pen=%b rv=%b err=%b to=%b pw=%b strb=%b required rdy=1 rest 0",
                     bus.cmd_ready, bus.busy, bus.psel, bus.penable, bus.rsp_valid,
                     bus.rsp_err, bus.rsp_timeout, bus.pwrite, bus.pstrb);
        end
        checks++;
        if ({bus.padd, bus.pwdata, bus.rsp_rdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: padd=%h pwdata=%h rdata=%h required 0",
                     bus.padd, bus.pwdata, bus.rsp_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_wait();
        int nsel;
        int nen;
        bit got;
        nsel = 0; nen = 0; got = 0;
        bus.pready0 = 1'b0;
        do_cmd(1'b1, 32'h79, 32'hE7, 4'b0001);
        checks++;
        if ({bus.pwrite, bus.padd, bus.pwdata, bus.pstrb, bus.penable} !==
            {1'b1, 32'h79, 32'hE7, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL wr_setup: pw=%b padd=%h pwdata=%h pstrb=%b pen=%b required 1 79 e7 0001 0",
                     bus.pwrite, bus.padd, bus.pwdata, bus.pstrb, bus.penable);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
            if (bus.psel === 2'b01) nsel++;
            if (bus.penable === 1'b1) nen++;
            if (nen == 3) bus.pready0 = 1'b1;
            tick();
        end
        bus.pready0 = 1'b0;
        checks++;
        if (!got || nsel != 4 || nen != 3) begin
            errors++;
            $display("FAIL wr_wait_cycles: rsp=%0d psel_cycles=%0d penable_cycles=%0d required 1 4 3",
                     got, nsel, nen);
        end
        checks++;
        if ({bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.psel, bus.penable} !== 36'd0) begin
            errors++;
            $display("FAIL wr_resp: err=%b to=%b rdata=%h psel=%b pen=%b required all 0",
                     bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.psel, bus.penable);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL wr_after: rv=%b rdy=%b busy=%b required 0 1 0",
                     bus.rsp_valid, bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_read_zero_wait();
        bus.prdata0 = 32'h0000_00E6;
        bus.pready0 = 1'b1;
        do_cmd(1'b0, 32'h78, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.padd} !==
            {2'b01, 1'b0, 1'b0, 4'b0000, 32'h78}) begin
            errors++;
            $display("FAIL rd_setup: psel=%b pen=%b pw=%b pstrb=%b padd=%h required 01 0 0 0000 78",
                     bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.padd);
        end
        tick();
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 4'b01_1_0) begin
            errors++;
            $display("FAIL rd_access: psel=%b pen=%b rv=%b required 01 1 0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hE6}) begin
            errors++;
            $display("FAIL rd_resp: rv=%b err=%b rdata=%h required 1 0 e6",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        bus.pready0 = 1'b0;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata} !== {1'b0, 1'b1, 32'hE6}) begin
            errors++;
            $display("FAIL rd_hold: rv=%b rdy=%b rdata=%h required 0 1 e6",
                     bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata);
        end
    endtask

    task automatic test_slave_error();
        bus.prdata0  = 32'hDEAD_BEEF;
        bus.pslevrr0 = 1'b0;
        bus.prdata1  = 32'h0000_005A;
        bus.pready1  = 1'b1;
        bus.pslevrr1 = 1'b1;
        do_cmd(1'b0, 32'h84, 32'h0, 4'b0000);
        checks++;
        if (bus.psel !== 2'b10) begin
            errors++;
            $display("FAIL slverr_psel: psel=%b required 10", bus.psel);
        end
        repeat (2) tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !==
            {1'b1, 1'b1, 1'b0, 32'h5A}) begin
            errors++;
            $display("FAIL slverr_resp: rv=%b err=%b to=%b rdata=%h required 1 1 0 5a",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        bus.pready1  = 1'b0;
        bus.pslevrr1 = 1'b0;
        tick();
    endtask

    task automatic test_decode_error();
        do_cmd(1'b1, 32'h100, 32'h1234, 4'b1111);
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.rsp_rdata} !==
            {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL decerr_resp: rv=%b err=%b to=%b psel=%b pen=%b rdata=%h required 1 1 0 00 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.rsp_rdata);
        end
        tick();
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== 4'b1_0_00) begin
            errors++;
            $display("FAIL decerr_after: rdy=%b rv=%b psel=%b required 1 0 00",
                     bus.cmd_ready, bus.rsp_valid, bus.psel);
        end
    endtask

    task automatic test_timeout();
        int nen;
        bit got;
        nen = 0; got = 0;
        bus.pready0 = 1'b0;
        do_cmd(1'b0, 32'h78, 32'h0, 4'b0000);
        for (int c = 0; c < 30; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
            if (bus.penable === 1'b1 && bus.psel === 2'b01) nen++;
            tick();
        end
        checks++;
        if (!got || nen != 8) begin
            errors++;
            $display("FAIL to_cycles: rsp=%0d access_cycles=%0d required 1 8", got, nen);
        end
        checks++;
        if ({bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.rsp_rdata} !==
            {1'b1, 1'b1, 2'b00, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL to_resp: err=%b to=%b psel=%b pen=%b rdata=%h required 1 1 00 0 0",
                     bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.rsp_rdata);
        end
        tick();
        // Next command to GPIO completes cleanly and clears the error flags.
        bus.pready1 = 1'b1;
        do_cmd(1'b1, 32'h85, 32'hA5A5_0001, 4'b0011);
        checks++;
        if ({bus.psel, bus.pstrb, bus.pwdata} !== {2'b10, 4'b0011, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL to_next_setup: psel=%b pstrb=%b pwdata=%h required 10 0011 a5a50001",
                     bus.psel, bus.pstrb, bus.pwdata);
        end
        repeat (2) tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL to_next_resp: rv=%b err=%b to=%b required 1 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout);
        end
        bus.pready1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        bit saw_rsp;
        saw_rsp = 0;
        bus.pready0 = 1'b0;
        do_cmd(1'b0, 32'h78, 32'h0, 4'b0000);
        repeat (2) tick();
        checks++;
        if ({bus.psel, bus.penable} !== 3'b01_1) begin
            errors++;
            $display("FAIL rstmid_pre: psel=%b pen=%b required 01 1", bus.psel, bus.penable);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.psel, bus.penable, bus.busy, bus.rsp_valid} !== 5'b00_0_0_0) begin
            errors++;
            $display("FAIL rstmid_abort: psel=%b pen=%b busy=%b rv=%b required 00 0 0 0",
                     bus.psel, bus.penable, bus.busy, bus.rsp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) saw_rsp = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) saw_rsp = 1;
        end
        checks++;
        if (saw_rsp || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release: rsp_seen=%0d rdy=%b required 0 1", saw_rsp, bus.cmd_ready);
        end
        bus.pready1 = 1'b1;
        do_cmd(1'b1, 32'h80, 32'h0000_0012, 4'b0001);
        repeat (2) tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !==
            {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_next: rv=%b err=%b to=%b rdata=%h required 1 0 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        bus.pready1 = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.prdata0   = '0;
        bus.prdata1   = '0;
        bus.pready0   = 1'b0;
        bus.pready1   = 1'b0;
        bus.pslevrr0  = 1'b0;
        bus.pslevrr1  = 1'b0;

        test_reset();
        test_write_wait();
        test_read_zero_wait();
        test_slave_error();
        test_decode_error();
        test_timeout();
        test_reset_mid_transfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
